// File: rtl/calc_disp_pkg.sv
// Shared display types: character codes, converter states and the 7-segment glyph table.
// Glyphs are active-high {g,f,e,d,c,b,a}; output polarity is applied by the consumer.
package calc_disp_pkg;

   localparam int MAG_W  = 11;
   localparam int BCD_W  = 12;
   localparam int DIGITS = 4;

   typedef logic [4:0] char_t;

   localparam char_t CH_BLANK = 5'd10;
   localparam char_t CH_MINUS = 5'd11;
   localparam char_t CH_E     = 5'd12;
   localparam char_t CH_R     = 5'd13;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} conv_state_t;

   function automatic logic [6:0] seg_decode(input char_t c);
      case (c)
         5'd0:     seg_decode = 7'b0111111;
         5'd1:     seg_decode = 7'b0000110;
         5'd2:     seg_decode = 7'b1011011;
         5'd3:     seg_decode = 7'b1001111;
         5'd4:     seg_decode = 7'b1100110;
         5'd5:     seg_decode = 7'b1101101;
         5'd6:     seg_decode = 7'b1111101;
         5'd7:     seg_decode = 7'b0000111;
         5'd8:     seg_decode = 7'b1111111;
         5'd9:     seg_decode = 7'b1101111;
         CH_MINUS: seg_decode = 7'b1000000;
         CH_E:     seg_decode = 7'b1111001;
         CH_R:     seg_decode = 7'b1010000;
         default:  seg_decode = 7'b0000000;
      endcase
   endfunction

endpackage

// File: rtl/result_display_if.sv
// Bus between the calculator operation stage (master) and the result display (slave).
interface result_display_if;
   logic [10:0] data_in;
   logic        err_in;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        busy;
   logic        bcd_valid;

   modport master (output data_in, err_in, input seg, dp, an, busy, bcd_valid);
   modport slave  (input data_in, err_in, output seg, dp, an, busy, bcd_valid);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: LOAD (1) + SHIFT (MAG_W) + DONE (1) cycles after start.
// i_mag is sampled in LOAD, so the caller must hold it stable from start until then.
module bin2bcd_seq
   import calc_disp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [MAG_W-1:0] i_mag,
   output logic [BCD_W-1:0] o_bcd,
   output logic             o_busy,
   output logic             o_done
);

   conv_state_t      r_state;
   logic [MAG_W-1:0] r_mag;
   logic [BCD_W-1:0] r_bcd;
   logic [3:0]       r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [BCD_W-1:0] w_adj;

   genvar g;
   generate
      for (g = 0; g < BCD_W/4; g++) begin : g_adj
         assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                            : r_bcd[4*g +: 4];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_mag   <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (i_start) begin
               r_state <= ST_LOAD;
               r_busy  <= 1'b1;
            end
            ST_LOAD: begin
               r_mag   <= i_mag;
               r_bcd   <= '0;
               r_cnt   <= '0;
               r_state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               {r_bcd, r_mag} <= {w_adj, r_mag} << 1;
               r_cnt          <= r_cnt + 4'd1;
               if (r_cnt == 4'(MAG_W-1)) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_bcd  = r_bcd;
   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

// File: rtl/result_display.sv
// Result display: change-detect + BCD conversion feeding a 4-digit multiplexed 7-seg scan.
// Digit registers only move when a conversion completes, so the scan never shows a partial value.
module result_display
   import calc_disp_pkg::*;
#(
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
)(
   input  logic             clk,
   input  logic             rst,
   result_display_if.slave  bus
);

   localparam int            RW       = $clog2(REFRESH_DIV);
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [6:0]    SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [3:0]    AN_OFF   = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
   localparam logic          DP_OFF   = SEG_ACTIVE_LOW;

   logic [MAG_W-1:0]             r_data;
   logic                         r_err;
   logic                         r_first;
   logic [DIGITS-1:0][4:0]       r_disp;
   logic                         r_valid;
   logic [RW-1:0]                r_refresh;
   logic [1:0]                   r_scan;
   logic [6:0]                   r_seg;
   logic [3:0]                   r_an;
   logic                         r_dp;

   logic                         w_start;
   logic                         w_busy;
   logic                         w_done;
   logic [BCD_W-1:0]             w_bcd;
   logic [MAG_W-1:0]             w_mag;
   logic [DIGITS-1:0][4:0]       w_next;
   logic [6:0]                   w_seg_hi;
   logic [3:0]                   w_an_hi;

   // Converter is idle only when not busy; a change seen mid-conversion waits for the next IDLE.
   assign w_start = !w_busy && (r_first || (bus.data_in != r_data) || (bus.err_in != r_err));
   assign w_mag   = r_data[MAG_W-1] ? (~r_data + 11'd1) : r_data;

   bin2bcd_seq u_bcd (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_start),
      .i_mag   (w_mag),
      .o_bcd   (w_bcd),
      .o_busy  (w_busy),
      .o_done  (w_done)
   );

   always_comb begin
      w_next = {CH_BLANK, CH_BLANK, CH_BLANK, 5'd0};
      if (r_err) begin
         w_next = {CH_E, CH_R, CH_R, CH_BLANK};
      end else if (w_mag > 11'd999) begin
         w_next = {DIGITS{CH_MINUS}};
      end else begin
         w_next[3] = r_data[MAG_W-1] ? CH_MINUS : CH_BLANK;
         w_next[2] = (w_bcd[11:8] == 4'd0) ? CH_BLANK : {1'b0, w_bcd[11:8]};
         w_next[1] = (w_bcd[11:4] == 8'd0) ? CH_BLANK : {1'b0, w_bcd[7:4]};
         w_next[0] = {1'b0, w_bcd[3:0]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data  <= '0;
         r_err   <= 1'b0;
         r_first <= 1'b1;
         r_disp  <= {CH_BLANK, CH_BLANK, CH_BLANK, 5'd0};
         r_valid <= 1'b0;
      end else begin
         if (w_start) begin
            r_data  <= bus.data_in;
            r_err   <= bus.err_in;
            r_first <= 1'b0;
         end
         if (w_done) begin
            r_disp  <= w_next;
            r_valid <= 1'b1;
         end
      end
   end

   assign w_seg_hi = seg_decode(r_disp[r_scan]);
   assign w_an_hi  = 4'b0001 << r_scan;

   // Scan is free-running; seg and an are registered from the same index so they switch together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_refresh <= '0;
         r_scan    <= 2'd0;
         r_seg     <= SEG_OFF;
         r_an      <= AN_OFF;
         r_dp      <= DP_OFF;
      end else begin
         if (r_refresh == REF_LAST) begin
            r_refresh <= '0;
            r_scan    <= r_scan + 2'd1;
         end else begin
            r_refresh <= r_refresh + RW'(1);
         end
         r_seg <= SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
         r_an  <= AN_ACTIVE_LOW  ? ~w_an_hi  : w_an_hi;
         r_dp  <= DP_OFF;
      end
   end

   assign bus.seg       = r_seg;
   assign bus.an        = r_an;
   assign bus.dp        = r_dp;
   assign bus.busy      = w_busy;
   assign bus.bcd_valid = r_valid;

endmodule
